// File: rtl/param_pipelined_cpu.sv
// Three-stage (fetch / execute / writeback) integer core with byte-loadable program memory.
// Executes R-type and I-type ALU operations with writeback forwarding, HALT, and restart.
module param_pipelined_cpu #(
    parameter int DATA_WIDTH = 8,
    parameter int PM_DEPTH   = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pmWrEn,
    input  logic [$clog2(PM_DEPTH)+1:0] pm_addr,
    input  logic [7:0]                  instructionIn,
    input  logic                        run,
    input  logic                        restart,
    output logic [DATA_WIDTH-1:0]       alu_result,
    output logic                        result_valid,
    output logic                        halted,
    output logic [$clog2(PM_DEPTH)-1:0] pc_out
);
    localparam int AW = $clog2(PM_DEPTH);
    localparam int SW = $clog2(DATA_WIDTH);
    localparam int RW = $clog2(NUM_REGS);
    localparam logic [6:0]  OP_R    = 7'b0110011;
    localparam logic [6:0]  OP_I    = 7'b0010011;
    localparam logic [6:0]  OP_HALT = 7'b1110011;
    localparam logic [31:0] BUBBLE  = 32'h0000_0000;

    logic [31:0]           pm_r [PM_DEPTH];
    logic [DATA_WIDTH-1:0] rf_r [NUM_REGS];
    logic [AW-1:0]         pc_r;
    logic [31:0]           ir_r;
    logic                  halted_r;
    logic                  wb_valid_r;
    logic [4:0]            wb_rd_r;
    logic [DATA_WIDTH-1:0] wb_result_r;

    logic [6:0]            op_s;
    logic [4:0]            rd_s, rs1_s, rs2_s;
    logic [2:0]            f3_s;
    logic                  is_r_s, is_i_s, exe_valid_s, exe_halt_s, fetch_en_s;
    logic [DATA_WIDTH-1:0] op1_s, op2_s, exe_result_s;

    function automatic logic [DATA_WIDTH-1:0] alu_f(
        input logic [2:0]            f3,
        input logic                  sub,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [SW-1:0] sh;
        sh = b[SW-1:0];
        case (f3)
            3'b000:  return sub ? (a - b) : (a + b);
            3'b001:  return a << sh;
            3'b010:  return DATA_WIDTH'($signed(a) < $signed(b));
            3'b100:  return a ^ b;
            3'b101:  return a >> sh;
            3'b110:  return a | b;
            3'b111:  return a & b;
            default: return '0;
        endcase
    endfunction

    // Decode, operand selection with writeback forwarding, and ALU evaluation
    always_comb begin
        op_s        = ir_r[6:0];
        rd_s        = ir_r[11:7];
        f3_s        = ir_r[14:12];
        rs1_s       = ir_r[19:15];
        rs2_s       = ir_r[24:20];
        is_r_s      = (op_s == OP_R);
        is_i_s      = (op_s == OP_I);
        exe_halt_s  = (op_s == OP_HALT);
        exe_valid_s = is_r_s || is_i_s;
        op1_s       = '0;
        op2_s       = '0;
        if (wb_valid_r && (wb_rd_r == rs1_s) && (rs1_s != 5'd0)) begin
            op1_s = wb_result_r;
        end else if ({1'b0, rs1_s} < 6'(NUM_REGS)) begin
            op1_s = rf_r[rs1_s[RW-1:0]];
        end else begin
            op1_s = '0;
        end
        if (!is_r_s) begin
            op2_s = DATA_WIDTH'($signed(ir_r[31:20]));
        end else if (wb_valid_r && (wb_rd_r == rs2_s) && (rs2_s != 5'd0)) begin
            op2_s = wb_result_r;
        end else if ({1'b0, rs2_s} < 6'(NUM_REGS)) begin
            op2_s = rf_r[rs2_s[RW-1:0]];
        end else begin
            op2_s = '0;
        end
        exe_result_s = alu_f(f3_s, is_r_s && ir_r[30], op1_s, op2_s);
        // A HALT in execute suppresses the fetch so pc stays on the following address
        fetch_en_s   = run && !halted_r && !restart && !exe_halt_s;
    end

    // Program memory byte loader; contents survive reset
    always_ff @(posedge clk) begin
        if (pmWrEn && !run) begin
            pm_r[pm_addr[AW+1:2]][{pm_addr[1:0], 3'b000} +: 8] <= instructionIn;
        end
    end

    // Fetch stage, halt flag and execute-to-writeback pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r        <= '0;
            ir_r        <= BUBBLE;
            halted_r    <= 1'b0;
            wb_valid_r  <= 1'b0;
            wb_rd_r     <= 5'd0;
            wb_result_r <= '0;
        end else begin
            if (restart) begin
                pc_r     <= '0;
                halted_r <= 1'b0;
                ir_r     <= BUBBLE;
            end else if (fetch_en_s) begin
                ir_r <= pm_r[pc_r];
                pc_r <= pc_r + 1'b1;
            end else begin
                ir_r <= BUBBLE;
                if (exe_halt_s) begin
                    halted_r <= 1'b1;
                end
            end
            wb_valid_r <= exe_valid_s;
            if (exe_valid_s) begin
                wb_rd_r     <= rd_s;
                wb_result_r <= exe_result_s;
            end
        end
    end

    // Register file writeback; x0 and out-of-range destinations are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_r[i] <= '0;
            end
        end else if (wb_valid_r && (wb_rd_r != 5'd0) && ({1'b0, wb_rd_r} < 6'(NUM_REGS))) begin
            rf_r[wb_rd_r[RW-1:0]] <= wb_result_r;
        end
    end

    assign alu_result   = wb_result_r;
    assign result_valid = wb_valid_r;
    assign halted       = halted_r;
    assign pc_out       = pc_r;
endmodule

// File: tb/tb_param_pipelined_cpu.sv
// Scoreboard bench for param_pipelined_cpu: expected retirements are queued when a
// program is started and compared in order as result_valid pulses are observed.
module tb_param_pipelined_cpu;
    localparam int DW = 8;
    localparam int PD = 32;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pmWrEn = 1'b0;
    logic [6:0]    pm_addr = 7'd0;
    logic [7:0]    instructionIn = 8'd0;
    logic          run = 1'b0;
    logic          restart = 1'b0;
    logic [DW-1:0] alu_result;
    logic          result_valid;
    logic          halted;
    logic [4:0]    pc_out;

    int            checks = 0;
    int            failures = 0;
    int            retire_cnt = 0;
    logic [31:0]   sb_q[$];
    logic [31:0]   prog_buf[PD];
    logic [31:0]   exp_a[14] = '{32'd5, 32'd8, 32'd251, 32'd1, 32'd7, 32'd0, 32'd10,
                                 32'd20, 32'd15, 32'd53, 32'd11, 32'd255, 32'd0, 32'd4};

    param_pipelined_cpu #(.DATA_WIDTH(DW), .PM_DEPTH(PD), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst), .pmWrEn(pmWrEn), .pm_addr(pm_addr),
        .instructionIn(instructionIn), .run(run), .restart(restart),
        .alu_result(alu_result), .result_valid(result_valid),
        .halted(halted), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input int rd, input int rs1, input logic [2:0] f3,
                                          input logic [11:0] imm);
        return {imm, 5'(rs1), f3, 5'(rd), 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load_prog();
        for (int k = 0; k < PD; k++) begin
            for (int b = 0; b < 4; b++) begin
                pm_addr       = 7'(k * 4 + b);
                instructionIn = prog_buf[k][8*b +: 8];
                pmWrEn        = 1'b1;
                tick();
            end
        end
        pmWrEn = 1'b0;
    endtask

    task automatic build_prog_a();
        for (int k = 0; k < PD; k++) prog_buf[k] = 32'h0000_0000;
        prog_buf[0]  = enc_i(1, 0, 3'b000, 12'd5);
        prog_buf[1]  = enc_i(2, 1, 3'b000, 12'd3);
        prog_buf[2]  = enc_r(7'h20, 1, 0, 3'b000, 3);
        prog_buf[3]  = enc_r(7'h00, 0, 3, 3'b010, 4);
        prog_buf[4]  = enc_i(0, 0, 3'b000, 12'd7);
        prog_buf[5]  = enc_r(7'h00, 0, 0, 3'b000, 5);
        prog_buf[6]  = enc_i(6, 1, 3'b100, 12'd15);
        prog_buf[7]  = enc_i(7, 1, 3'b001, 12'd2);
        prog_buf[8]  = enc_i(8, 3, 3'b101, 12'd4);
        prog_buf[9]  = enc_i(9, 1, 3'b110, 12'h030);
        prog_buf[10] = enc_i(10, 3, 3'b111, 12'd15);
        prog_buf[11] = enc_i(11, 0, 3'b000, 12'hFFF);
        prog_buf[12] = enc_r(7'h00, 11, 0, 3'b010, 12);
        prog_buf[13] = enc_r(7'h00, 1, 11, 3'b000, 13);
        prog_buf[14] = 32'h0000_0073;
    endtask

    task automatic push_a();
        foreach (exp_a[i]) sb_q.push_back(exp_a[i]);
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halted && n < 80) begin
            tick();
            n++;
        end
        check_eq({tag, "_halted"}, 32'(halted), 32'd1);
        check_eq({tag, "_halt_pc"}, 32'(pc_out), 32'd15);
    endtask

    task automatic drain(input string tag);
        repeat (4) tick();
        check_eq({tag, "_sb_drain"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_eq("restart_halted", 32'(halted), 32'd0);
        check_eq("restart_pc", 32'(pc_out), 32'd0);
    endtask

    // Scoreboard: every retirement must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst && result_valid) begin
            retire_cnt++;
            if (sb_q.size() == 0) check_eq("sb_pending", 32'(sb_q.size()), 32'd1);
            else check_eq("sb_result", 32'(alu_result), sb_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int base;
        int rc0;
        logic [31:0] pc0;

        repeat (2) tick();
        check_eq("rst_pc", 32'(pc_out), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_valid", 32'(result_valid), 32'd0);
        check_eq("rst_result", 32'(alu_result), 32'd0);
        build_prog_a();
        load_prog();

        // Program A from reset release: latency, forwarding, wrap arithmetic, x0, halt
        rst = 1'b1;
        run = 1'b1;
        push_a();
        tick();
        check_eq("lat_e1_valid", 32'(result_valid), 32'd0);
        check_eq("lat_e1_pc", 32'(pc_out), 32'd1);
        tick();
        check_eq("lat_e2_valid", 32'(result_valid), 32'd1);
        wait_halt("t1");
        pm_addr       = 7'd0;
        instructionIn = 8'h00;
        pmWrEn        = 1'b1;
        tick();
        pmWrEn = 1'b0;
        check_eq("t1_halt_hold_pc", 32'(pc_out), 32'd15);
        drain("t1");

        // Restart re-executes from word 0; run dropped for 3 cycles mid-stream
        pulse_restart();
        push_a();
        base = retire_cnt;
        for (int i = 0; i < 20 && (retire_cnt - base) < 4; i++) tick();
        run = 1'b0;
        rc0 = retire_cnt;
        pc0 = 32'(pc_out);
        repeat (3) tick();
        check_eq("gate_one_retire", 32'(retire_cnt - rc0), 32'd1);
        check_eq("gate_pc_held", 32'(pc_out), pc0);
        run = 1'b1;
        wait_halt("t2");
        drain("t2");

        // PC wrap with an instruction at the last word feeding word 0 on the second pass
        run = 1'b0;
        tick();
        for (int k = 0; k < PD; k++) prog_buf[k] = 32'h0000_0000;
        prog_buf[0]  = enc_i(2, 1, 3'b000, 12'd1);
        prog_buf[31] = enc_i(1, 0, 3'b000, 12'd9);
        load_prog();
        pulse_restart();
        sb_q.push_back(32'd6);
        sb_q.push_back(32'd9);
        sb_q.push_back(32'd10);
        run = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            tick();
            check_eq("wrap_pc", 32'(pc_out), 32'(k % PD));
        end
        run = 1'b0;
        drain("t3");

        // Asynchronous reset while results stream, then identical replay
        build_prog_a();
        load_prog();
        pulse_restart();
        push_a();
        run = 1'b1;
        base = retire_cnt;
        for (int i = 0; i < 20 && (retire_cnt - base) < 6; i++) tick();
        rst = 1'b0;
        #1;
        check_eq("async_pc", 32'(pc_out), 32'd0);
        check_eq("async_valid", 32'(result_valid), 32'd0);
        check_eq("async_result", 32'(alu_result), 32'd0);
        check_eq("async_halted", 32'(halted), 32'd0);
        sb_q.delete();
        tick();
        rst = 1'b1;
        push_a();
        tick();
        check_eq("replay_pc", 32'(pc_out), 32'd1);
        wait_halt("t4");
        drain("t4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
